// File: rtl/key_cmd_sched.sv
// PS/2 scancode sequencer: turns make/break bytes for four control keys into
// one-hot commands on a valid/ready port. Auto-repeat enabled by KEY_AUTOREPEAT_EN.
module key_cmd_sched #(
    parameter int CLK_DIV      = 5000000,
    parameter int REPEAT_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] key_held
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    if (CLK_DIV < 2 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("key_cmd_sched: CLK_DIV must be >= 2 and REPEAT_TICKS >= 1");
    end

    function automatic logic [3:0] keyMap(input logic [7:0] code);
        case (code)
            8'h1C:   keyMap = 4'b0001;
            8'h1B:   keyMap = 4'b0010;
            8'h23:   keyMap = 4'b0100;
            8'h2B:   keyMap = 4'b1000;
            default: keyMap = 4'b0000;
        endcase
    endfunction

    logic [1:0] state_q, state_d;
    logic [3:0] held_q, held_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [1:0] rr_q, rr_d;

    logic [3:0] make_vec, brk_vec, make_new, rep_fire;
    logic [3:0] grant_vec, pend_clr;
    logic [1:0] grant_idx, search_idx;
    logic       grant_found, slot_free;

    // Prefix parser: only a non-extended F0 followed by a mapped code is a break.
    always_comb begin
        state_d  = state_q;
        make_vec = '0;
        brk_vec  = '0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == 8'hF0)      state_d = ST_BRK;
                    else if (scan_code == 8'hE0) state_d = ST_EXT;
                    else                         make_vec = keyMap(scan_code);
                end
                ST_BRK: begin
                    brk_vec = keyMap(scan_code);
                    state_d = ST_IDLE;
                end
                ST_EXT:  state_d = (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A make on an already-held key is keyboard typematic and is dropped.
    assign make_new = make_vec & ~held_q;
    assign held_d   = (held_q | make_new) & ~brk_vec;

`ifdef KEY_AUTOREPEAT_EN
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RC_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [RC_W-1:0]  rep_cnt_q [4];
    logic [RC_W-1:0]  rep_cnt_d [4];

    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // Break or fresh make restarts the count, so a break beats a same-cycle expiry.
    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 4; k++) begin
            rep_cnt_d[k] = rep_cnt_q[k];
            if (brk_vec[k] || make_new[k]) begin
                rep_cnt_d[k] = '0;
            end else if (held_q[k] && tick) begin
                if (rep_cnt_q[k] == RC_W'(REPEAT_TICKS - 1)) begin
                    rep_fire[k]  = 1'b1;
                    rep_cnt_d[k] = '0;
                end else begin
                    rep_cnt_d[k] = rep_cnt_q[k] + RC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            for (int k = 0; k < 4; k++) rep_cnt_q[k] <= '0;
        end else begin
            div_q <= div_d;
            for (int k = 0; k < 4; k++) rep_cnt_q[k] <= rep_cnt_d[k];
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign slot_free = ~cmd_valid_q | cmd_ready;

    // Round-robin search starting at rr_q, wrapping through all four keys.
    always_comb begin
        grant_vec   = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        search_idx  = '0;
        for (int i = 0; i < 4; i++) begin
            search_idx = rr_q + 2'(i);
            if (!grant_found && pend_q[search_idx]) begin
                grant_found           = 1'b1;
                grant_idx             = search_idx;
                grant_vec[search_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        rr_d        = rr_q;
        pend_clr    = '0;
        if (slot_free) begin
            if (grant_found) begin
                cmd_d       = grant_vec;
                cmd_valid_d = 1'b1;
                pend_clr    = grant_vec;
                rr_d        = grant_idx + 2'd1;
            end else begin
                cmd_d       = '0;
                cmd_valid_d = 1'b0;
            end
        end
    end

    // New events are OR-ed in after the grant clear so a same-cycle set survives.
    assign pend_d = (pend_q & ~pend_clr) | make_new | rep_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            pend_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            pend_q      <= pend_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            rr_q        <= rr_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Self-checking bench for key_cmd_sched: vector table, directed corner cases
// and random scancode traffic compared against a behavioural key model.
module tb_key_cmd_sched;

    localparam int CLK_DIV      = 10;
    localparam int REPEAT_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code = '0;
    logic       scan_valid = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [3:0] key_held;

    int nChecks = 0;
    int nErrors = 0;

    key_cmd_sched #(.CLK_DIV(CLK_DIV), .REPEAT_TICKS(REPEAT_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-key arrays, prefix flags, cycle count since reset.
    int  mHeld [4];
    int  mPend [4];
    int  mRep  [4];
    bit  mBrkPfx, mExtPfx;
    bit  mValid;
    int  mCmdIdx;
    int  mRr;
    int  mCyc;

    function automatic int keyIndex(input logic [7:0] code);
        case (code)
            8'h1C:   return 0;
            8'h1B:   return 1;
            8'h23:   return 2;
            8'h2B:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            mHeld[k] = 0; mPend[k] = 0; mRep[k] = 0;
        end
        mBrkPfx = 0; mExtPfx = 0; mValid = 0; mCmdIdx = 0; mRr = 0; mCyc = 0;
    endtask

    task automatic modelStep(input logic [7:0] code, input bit v, input bit rdy);
        int  mk, bk, g;
        bit  tick;
        mk = -1; bk = -1; g = -1;
        if (!mValid || rdy) begin
            for (int i = 0; i < 4; i++)
                if (g < 0 && mPend[(mRr + i) % 4] != 0) g = (mRr + i) % 4;
            if (g >= 0) begin
                mValid = 1; mCmdIdx = g; mPend[g] = 0; mRr = (g + 1) % 4;
            end else begin
                mValid = 0;
            end
        end
        if (v) begin
            if (mExtPfx) begin
                if (!mBrkPfx && code == 8'hF0) mBrkPfx = 1;
                else begin mExtPfx = 0; mBrkPfx = 0; end
            end else if (mBrkPfx) begin
                bk = keyIndex(code); mBrkPfx = 0;
            end else if (code == 8'hF0) mBrkPfx = 1;
            else if (code == 8'hE0) mExtPfx = 1;
            else mk = keyIndex(code);
        end
`ifdef KEY_AUTOREPEAT_EN
        tick = ((mCyc % CLK_DIV) == CLK_DIV - 1);
`else
        tick = 0;
`endif
        mCyc++;
        for (int k = 0; k < 4; k++) begin
            if (k == bk) begin
                mHeld[k] = 0; mRep[k] = 0;
            end else if (k == mk && mHeld[k] == 0) begin
                mHeld[k] = 1; mPend[k] = 1; mRep[k] = 0;
            end else if (mHeld[k] != 0 && tick) begin
                mRep[k]++;
                if (mRep[k] == REPEAT_TICKS) begin mPend[k] = 1; mRep[k] = 0; end
            end
        end
    endtask

    function automatic logic [3:0] modelHeld();
        logic [3:0] h;
        for (int k = 0; k < 4; k++) h[k] = (mHeld[k] != 0);
        return h;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance model on the edge, compare just after it.
    task automatic applyStimulus(input logic [7:0] code, input bit v, input bit rdy);
        scan_code = code; scan_valid = v; cmd_ready = rdy;
        @(posedge clk);
        if (!rst_n) modelReset();
        else modelStep(code, v, rdy);
        #1;
        checkOutput("model_cmd", int'(cmd), mValid ? (1 << mCmdIdx) : 0);
        checkOutput("model_valid", int'(cmd_valid), int'(mValid));
        checkOutput("model_held", int'(key_held), int'(modelHeld()));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        applyStimulus(8'h00, 0, 0);
        applyStimulus(8'h00, 0, 0);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] code;
        logic       valid;
        logic       ready;
        logic [3:0] expCmd;
        logic       expValid;
        logic [3:0] expHeld;
    } vec_t;

    vec_t vecs [14];
    int   cnt;

    initial begin
        vecs[0]  = '{8'h23, 1, 1, 4'b0000, 0, 4'b0100};
        vecs[1]  = '{8'h00, 0, 1, 4'b0100, 1, 4'b0100};
        vecs[2]  = '{8'hF0, 1, 1, 4'b0000, 0, 4'b0100};
        vecs[3]  = '{8'h23, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[4]  = '{8'hE0, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[5]  = '{8'h1C, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[6]  = '{8'hE0, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[7]  = '{8'hF0, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[8]  = '{8'h1C, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[9]  = '{8'h15, 1, 1, 4'b0000, 0, 4'b0000};
        vecs[10] = '{8'h1B, 1, 1, 4'b0000, 0, 4'b0010};
        vecs[11] = '{8'h00, 0, 1, 4'b0010, 1, 4'b0010};
        vecs[12] = '{8'hF0, 1, 1, 4'b0000, 0, 4'b0010};
        vecs[13] = '{8'h1B, 1, 1, 4'b0000, 0, 4'b0000};

        modelReset();
        applyStimulus(8'h00, 0, 0);
        checkOutput("reset_valid", int'(cmd_valid), 0);
        checkOutput("reset_cmd", int'(cmd), 0);
        checkOutput("reset_held", int'(key_held), 0);
        #2 rst_n = 1'b1;

        // Tap D latency/width, then extended and unmapped bytes leave no trace.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].code, vecs[i].valid, vecs[i].ready);
            checkOutput($sformatf("vec%0d_cmd", i), int'(cmd), int'(vecs[i].expCmd));
            checkOutput($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_held", i), int'(key_held), int'(vecs[i].expHeld));
        end

        // Async reset while a break prefix is pending.
        doReset();
        applyStimulus(8'h1C, 1, 1);
        applyStimulus(8'h00, 0, 1);
        applyStimulus(8'hF0, 1, 1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_held", int'(key_held), 0);
        checkOutput("async_rst_valid", int'(cmd_valid), 0);
        applyStimulus(8'h00, 0, 1);
        #2 rst_n = 1'b1;
        cnt = 0;
        applyStimulus(8'h1C, 1, 1); if (cmd_valid && cmd == 4'b0001) cnt++;
        applyStimulus(8'hF0, 1, 1); if (cmd_valid && cmd == 4'b0001) cnt++;
        applyStimulus(8'h1C, 1, 1); if (cmd_valid && cmd == 4'b0001) cnt++;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 0, 1); if (cmd_valid) cnt++;
        end
        checkOutput("rst_prefix_cmds", cnt, 1);
        checkOutput("rst_prefix_held", int'(key_held), 0);

        // Back-pressure then drain in round-robin order.
        doReset();
        applyStimulus(8'h1C, 1, 0);
        applyStimulus(8'h1B, 1, 0);
        applyStimulus(8'h23, 1, 0);
        applyStimulus(8'h2B, 1, 0);
        applyStimulus(8'h00, 0, 0);
        checkOutput("rr_stall_cmd", int'(cmd), 4'b0001);
        checkOutput("rr_stall_valid", int'(cmd_valid), 1);
        applyStimulus(8'h00, 0, 1); checkOutput("rr_cmd1", int'(cmd), 4'b0010);
        applyStimulus(8'h00, 0, 1); checkOutput("rr_cmd2", int'(cmd), 4'b0100);
        applyStimulus(8'h00, 0, 1); checkOutput("rr_cmd3", int'(cmd), 4'b1000);
        applyStimulus(8'h00, 0, 1); checkOutput("rr_drained", int'(cmd_valid), 0);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] codes [4];
            codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
            applyStimulus(8'hF0, 1, 1);
            applyStimulus(codes[k], 1, 1);
        end
        applyStimulus(8'h1B, 1, 0);
        applyStimulus(8'h1C, 1, 0);
        applyStimulus(8'h00, 0, 0);
        checkOutput("rr_wrap_first", int'(cmd), 4'b0010);
        applyStimulus(8'h00, 0, 1);
        checkOutput("rr_wrap_second", int'(cmd), 4'b0001);

`ifdef KEY_AUTOREPEAT_EN
        // Hold A: first command, then one repeat per REPEAT_TICKS ticks.
        doReset();
        cnt = 0;
        applyStimulus(8'h1C, 1, 1); if (cmd_valid) cnt++;
        for (int i = 1; i <= 70; i++) begin
            applyStimulus((i == 30) ? 8'h1C : 8'h00, i == 30, 1);
            if (cmd_valid && cmd == 4'b0001) cnt++;
        end
        checkOutput("repeat_count", cnt, 4);
        cnt = 0;
        applyStimulus(8'hF0, 1, 1); if (cmd_valid) cnt++;
        applyStimulus(8'h1C, 1, 1); if (cmd_valid) cnt++;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'h00, 0, 1); if (cmd_valid) cnt++;
        end
        checkOutput("repeat_stopped", cnt, 0);
`else
        doReset();
        cnt = 0;
        applyStimulus(8'h2B, 1, 1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(8'h00, 0, 1);
            if (cmd_valid && cmd == 4'b1000) cnt++;
        end
        checkOutput("no_repeat_count", cnt, 1);
`endif

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] pool [7];
            logic [7:0] c;
            pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'h15};
            c = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 6)] : 8'($urandom);
            applyStimulus(c, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
